// File: rtl/sync_fifo_ext_if.sv
// Write/read handshake, data and status bundle for sync_fifo_ext.
// master = FIFO user, slave = the FIFO itself.
interface sync_fifo_ext_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             flush_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] write_data_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] read_data_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output flush_i, wr_en_i, write_data_i, rd_en_i,
        input  read_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, write_data_i, rd_en_i,
        output read_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO, any DEPTH >= 2, standard or first-word-fall-through read,
// occupancy count, almost thresholds, flush and sticky overflow/underflow.
module sync_fifo_ext #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter bit FWFT  = 1'b0,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_ext_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf_q;
    logic             unf_q;
    logic             full;
    logic             empty;
    logic             rd_acc;
    logic             wr_acc;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign rd_acc = bus.rd_en_i & ~empty;
    assign wr_acc = bus.wr_en_i & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_acc && !rd_acc)      count <= count + CW'(1);
            else if (rd_acc && !wr_acc) count <= count - CW'(1);
            if (bus.wr_en_i && !wr_acc) ovf_q <= 1'b1;
            if (bus.rd_en_i && !rd_acc) unf_q <= 1'b1;
        end
    end

    // When full, a simultaneous pop reads the old word at the same slot.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush_i && wr_acc) mem[wr_ptr] <= bus.write_data_i;
    end

    if (FWFT) begin : g_fwft
        assign bus.read_data_o = mem[rd_ptr];
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (!rst_n || bus.flush_i) rdata_q <= '0;
            else if (rd_acc)           rdata_q <= mem[rd_ptr];
        end
        assign bus.read_data_o = rdata_q;
    end

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (int'(count) >= AF_TH);
    assign bus.almost_empty_o = (int'(count) <= AE_TH);
    assign bus.count_o        = count;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised synchronous single-clock FIFO for controller data paths such as UART/SPI command and response buffering.
- Supports any DEPTH ≥ 2, including non-power-of-2.
- Selectable standard (registered read) or first-word-fall-through (FWFT) read mode.
- Provides an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
- DEPTH, 8, number of entries; any integer ≥ 2.
- WIDTH, 8, data word width in bits.
- FWFT, 0, 0 = standard mode (data appears 1 cycle after read); 1 = head word presented combinationally while not empty.
- AF_TH, DEPTH-1, almost_full_o asserted when count_o ≥ AF_TH.
- AE_TH, 1, almost_empty_o asserted when count_o ≤ AE_TH.
- CW, $clog2(DEPTH+1), count width (derived; not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush_i  in  1  synchronous clear of contents and error flags.
- wr_en_i  in  1  write request.
- write_data_i  in  WIDTH  write data.
- rd_en_i  in  1  read request / pop.
- read_data_o  out  WIDTH  read data.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- almost_full_o  out  1  count_o ≥ AF_TH.
- almost_empty_o  out  1  count_o ≤ AE_TH.
- count_o  out  CW  current number of stored words.
- overflow_o  out  1  sticky: a write was rejected.
- underflow_o  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n=0 at clk edge) has top priority:
  - pointers = 0, count_o = 0, read_data_o = 0, overflow_o = underflow_o = 0.
  - Resulting flags: empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (AF_TH == 0).
  - Reset mid-operation discards all contents; no partial writes survive.
- Flush (flush_i=1, rst_n=1): same effect as reset on pointers, count and error flags.
  - read_data_o is cleared to 0 in standard mode.
  - Any wr_en_i/rd_en_i in the same cycle is ignored and does not set error flags.
- Pointers:
  - wr_ptr and rd_ptr each range 0..DEPTH-1 and wrap explicitly: DEPTH-1 → 0, not by bit overflow.
  - Full/empty are derived from count_o, never from pointer comparison.
- Read acceptance: rd_acc = rd_en_i & !empty_o.
- Write acceptance: wr_acc = wr_en_i & (!full_o | rd_acc).
  - When full, a simultaneous read frees a slot, so both are accepted.
  - When empty, a simultaneous read is rejected and the write is accepted.
- Count update:
  - count_o += 1 if wr_acc & !rd_acc.
  - count_o -= 1 if rd_acc & !wr_acc.
  - Unchanged otherwise.
  - count_o never exceeds DEPTH and never goes negative.
- Error flags:
  - wr_en_i & !wr_acc sets overflow_o on the next edge.
  - rd_en_i & !rd_acc sets underflow_o on the next edge.
  - Both hold until reset or flush.
  - Rejected operations change no other state.
- Standard mode (FWFT=0):
  - On rd_acc, read_data_o <= mem[rd_ptr] at that edge; latency 1 cycle.
  - read_data_o holds its last value otherwise.
- FWFT mode (FWFT=1):
  - read_data_o = mem[rd_ptr] combinationally while !empty_o; rd_en_i pops the word.
  - A word written into an empty FIFO is visible the cycle after the write edge.
  - read_data_o is don't-care while empty; the bench must not check it.
- Status flags are combinational from count_o and update in the same cycle count_o changes.
- All outputs are synchronous to clk; no combinational path from wr_en_i or rd_en_i to any output.

Test Plan:
- DEPTH=5, WIDTH=8, FWFT=0: write 0x11..0x15 in 5 cycles.
  - → full_o=1, count_o=5.
  - 6th write 0x16 → rejected, overflow_o=1, count_o stays 5.
  - Read 5 → read_data_o = 0x11..0x15 each 1 cycle after rd_en_i.
  - Then empty_o=1.
- DEPTH=5, full FIFO: wr_en_i=rd_en_i=1 for 7 cycles with incrementing data.
  - → count_o stays 5, no overflow.
  - Output order is preserved across pointer wrap 4 → 0.
- Empty FIFO: rd_en_i=1 with wr_en_i=1 (0xA5).
  - → underflow_o=1, count_o=1.
  - Next read returns 0xA5.
- FWFT=1: write 0x3C into an empty FIFO.
  - → next cycle empty_o=0, read_data_o=0x3C with no rd_en_i.
  - Pulse rd_en_i → empty_o=1 next cycle.
- DEPTH=8, AF_TH=6, AE_TH=2: fill one word per cycle.
  - → almost_empty_o deasserts at count 3.
  - → almost_full_o asserts at count 6.
- Flush with 4 words stored plus overflow_o set, with wr_en_i=1 in the same cycle.
  - → count_o=0, empty_o=1, overflow_o=0, write dropped.
  - Then repeat with rst_n=0 asserted mid-fill → same cleared state.
